// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep controller.
package tt_sweep_pkg;

    localparam int unsigned TT_ROWS  = 8;
    localparam int unsigned TT_WIDTH = 8;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned CNT_W    = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter reload so that SETTLE lasts exactly `eff` cycles (counts eff-1 down to 0).
    function automatic logic [CNT_W-1:0] settle_reload(input int unsigned eff);
        return CNT_W'(eff - 1);
    endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for the asynchronous gate output; both flops reset to 0.
module tt_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks a 3-input gate through all 8 input rows and records its truth table.
// Define TT_SWEEP_SYNC_EN to synchronize gate_out (adds 2 settle cycles per row).
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [TT_WIDTH-1:0] expected,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    input  logic                gate_out,
    output logic                busy,
    output logic                done,
    output logic [TT_WIDTH-1:0] table_out,
    output logic                match
);

    logic w_gate;

`ifdef TT_SWEEP_SYNC_EN
    localparam int unsigned SETTLE_EFF = SETTLE_CYCLES + 2;

    tt_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gate_out),
        .q     (w_gate)
    );
`else
    localparam int unsigned SETTLE_EFF = SETTLE_CYCLES;

    assign w_gate = gate_out;
`endif

    localparam logic [CNT_W-1:0] RELOAD   = settle_reload(SETTLE_EFF);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TT_ROWS - 1);

    state_t                r_state, w_state;
    logic [ROW_W-1:0]      r_row,   w_row;
    logic [CNT_W-1:0]      r_cnt,   w_cnt;
    logic [TT_WIDTH-1:0]   r_exp,   w_exp;
    logic [TT_WIDTH-1:0]   r_table, w_table;
    logic                  r_match, w_match;
    logic                  r_busy,  w_busy;
    logic                  r_done,  w_done;
    logic [ROW_W-1:0]      r_ins,   w_ins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_cnt   <= '0;
            r_exp   <= '0;
            r_table <= '0;
            r_match <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ins   <= '0;
        end else begin
            r_state <= w_state;
            r_row   <= w_row;
            r_cnt   <= w_cnt;
            r_exp   <= w_exp;
            r_table <= w_table;
            r_match <= w_match;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ins   <= w_ins;
        end
    end

    // Next state and next values of every registered output; abort outranks start.
    always_comb begin
        w_state = r_state;
        w_row   = r_row;
        w_cnt   = r_cnt;
        w_exp   = r_exp;
        w_table = r_table;
        w_match = r_match;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state = SETTLE;
                    w_row   = '0;
                    w_cnt   = RELOAD;
                    w_exp   = expected;
                    w_table = '0;
                    w_match = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_state = IDLE;
                    w_match = 1'b0;
                end else if (r_cnt == '0) begin
                    w_state = SAMPLE;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    w_state = IDLE;
                    w_match = 1'b0;
                end else begin
                    w_table[LAST_ROW - r_row] = w_gate;
                    if (r_row == LAST_ROW) begin
                        w_state = DONE;
                        w_match = (w_table == r_exp);
                    end else begin
                        w_state = SETTLE;
                        w_row   = r_row + ROW_W'(1);
                        w_cnt   = RELOAD;
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state == SETTLE) || (w_state == SAMPLE);
        w_done = (w_state == DONE);
        w_ins  = w_busy ? w_row : '0;
    end

    assign {in1, in2, in3} = r_ins;
    assign busy            = r_busy;
    assign done            = r_done;
    assign table_out       = r_table;
    assign match           = r_match;

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving gate settle cycles per row (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a sweep.
REQ-005 SHALL have port abort, input, 1, which cancels a sweep in progress.
REQ-006 SHALL have port expected, input, 8, the reference truth table in gate-name order, sampled at start.
REQ-007 SHALL have ports in1, in2, in3, output, 1 each, which drive the 3-input gate under test.
REQ-008 SHALL have port gate_out, input, 1, the gate's output, possibly asynchronous.
REQ-009 SHALL have port busy, output, 1, asserted while a sweep is active.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at sweep completion.
REQ-011 SHALL have port table_out, output, 8, the measured truth table.
REQ-012 SHALL have port match, output, 1, equal to (table_out == expected latched), valid while done is high and held until the next start.

Function
REQ-013 SHALL implement the FSM IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
REQ-014 SHALL, in IDLE, drive {in1,in2,in3}=3'b000 and hold busy=0.
REQ-015 SHALL, on start in IDLE, on the next edge: enter SETTLE, set row=0, clear table_out, latch expected, set busy=1, and load the settle counter.
REQ-016 SHALL always drive {in1,in2,in3}=row (in1 is the MSB) while busy.
REQ-017 SHALL remain in SETTLE exactly SETTLE_EFF cycles, then spend exactly 1 cycle in SAMPLE, which writes table_out[7-row] = sampled gate_out; a correct gate 0x39 therefore yields table_out=8'h39.
REQ-018 SHALL, from SAMPLE with row<7, increment row and re-enter SETTLE with the counter reloaded.
REQ-019 SHALL, from SAMPLE with row==7, enter DONE.
REQ-020 SHALL spend 1 cycle in DONE with done=1, busy=0 and match updated, then return to IDLE; table_out holds its value until the next start.
REQ-021 SHALL complete a sweep in exactly 8*(SETTLE_EFF+1) cycles from the start-accept edge to entry into DONE.
REQ-022 SHALL ignore start while busy or in DONE.
REQ-023 SHALL, on abort while busy, return to IDLE on the next edge with no done pulse, match=0, table_out keeping the partial result, and inputs at 000.
REQ-024 SHALL give abort priority over start when both are asserted in the same cycle (abort has no effect in IDLE, where start is honoured).
REQ-025 SHALL use a row counter that never wraps; row 7 always terminates the sweep.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: state=IDLE, row=0, counter=0, in1..in3=0, busy=0, done=0, match=0, table_out=8'h00, latched expected=8'h00.
REQ-027 SHALL treat reset asserted mid-sweep as an abort with full clearing; after deassertion the first start is accepted normally.

Configuration
REQ-028 SHALL, with TT_SWEEP_SYNC_EN defined, pass gate_out through a 2-flop synchronizer (reset to 0) before sampling, with SETTLE_EFF=SETTLE_CYCLES+2.
REQ-029 SHALL, with TT_SWEEP_SYNC_EN undefined, sample gate_out directly, with SETTLE_EFF=SETTLE_CYCLES.

Structure
REQ-030 SHALL place the state enum (IDLE, SETTLE, SAMPLE, DONE), TT_ROWS=8 and TT_WIDTH=8 in the shared package tt_sweep_pkg.
REQ-031 SHALL implement the synchronizer as sub-module tt_sync2, instantiated only under TT_SWEEP_SYNC_EN.

Verification
REQ-032 SHALL cover: model gate 0x39, expected=8'h39, SETTLE_CYCLES=4, no macro -> done in cycle 40 after accept, table_out=8'h39, match=1.
REQ-033 SHALL cover: gate_out stuck at 1, expected=8'h39 -> table_out=8'hFF, match=0.
REQ-034 SHALL cover: abort during row 3 -> busy falls next cycle, no done, table_out[7:5]=3'b001, inputs return to 000.
REQ-035 SHALL cover: start re-pulsed during a sweep -> no restart, total sweep length unchanged.
REQ-036 SHALL cover: rst_n pulsed low mid-sweep -> all outputs 0 immediately, then a fresh sweep passes.
REQ-037 SHALL cover: TT_SWEEP_SYNC_EN defined, SETTLE_CYCLES=4 -> sweep takes 56 cycles and table_out=8'h39.
